// File: rtl/uop_queue_pkg.sv
// Shared widths, the packed uop bundle and the issue-queue FSM states.
// Bundle widths follow the default NUM_UOPS/XLEN/ARCHFILE_SIZE of uop_issue_queue.
package uop_queue_pkg;

    localparam int unsigned NUM_UOPS_DEF      = 128;
    localparam int unsigned XLEN_DEF          = 32;
    localparam int unsigned ARCHFILE_SIZE_DEF = 16;

    localparam int unsigned UOP_W = $clog2(NUM_UOPS_DEF);
    localparam int unsigned IMM_W = XLEN_DEF;
    localparam int unsigned REG_W = $clog2(ARCHFILE_SIZE_DEF);
    localparam int unsigned PC_W  = 32;

    typedef struct packed {
        logic [UOP_W-1:0] uop;
        logic             eoi;
        logic [IMM_W-1:0] imm;
        logic             use_imm;
        logic [PC_W-1:0]  pc;
        logic             except;
        logic [REG_W-1:0] src1_arch;
        logic [REG_W-1:0] src2_arch;
        logic [REG_W-1:0] dest_arch;
    } uop_bundle_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } q_state_e;

endpackage

// File: rtl/uop_queue_mem.sv
// DEPTH x uop_bundle_t register array: one write port, asynchronous read,
// synchronous clear on active-low reset.
module uop_queue_mem
    import uop_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  uop_bundle_t   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output uop_bundle_t   o_rdata
);

    uop_bundle_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uop_issue_queue.sv
// Decoupling FIFO between decoder and backend with flush and exception halt.
// Optional combinational empty-queue bypass: define UOP_QUEUE_BYPASS_EN.
module uop_issue_queue
    import uop_queue_pkg::*;
#(
    parameter int unsigned NUM_UOPS      = 128,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ARCHFILE_SIZE = 16,
    parameter int unsigned DEPTH         = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [$clog2(NUM_UOPS)-1:0]      in_uop,
    input  logic                             in_eoi,
    input  logic [XLEN-1:0]                  in_imm,
    input  logic                             in_use_imm,
    input  logic [31:0]                      in_pc,
    input  logic                             in_except,
    input  logic [$clog2(ARCHFILE_SIZE)-1:0] in_src1_arch,
    input  logic [$clog2(ARCHFILE_SIZE)-1:0] in_src2_arch,
    input  logic [$clog2(ARCHFILE_SIZE)-1:0] in_dest_arch,
    output logic                             uop_ready,
    input  logic                             uop_accept,
    output logic [$clog2(NUM_UOPS)-1:0]      uop,
    output logic                             eoi,
    output logic [XLEN-1:0]                  imm,
    output logic                             use_imm,
    output logic [31:0]                      pc,
    output logic                             except,
    output logic [$clog2(ARCHFILE_SIZE)-1:0] src1_arch,
    output logic [$clog2(ARCHFILE_SIZE)-1:0] src2_arch,
    output logic [$clog2(ARCHFILE_SIZE)-1:0] dest_arch,
    input  logic                             flush,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic [$clog2(DEPTH+1)-1:0]       inst_count,
    output logic                             halted
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W:0]   PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [PTR_W:0]   r_head, r_tail;
    logic [CNT_W-1:0] r_count, r_inst_count;
    q_state_e         r_state, w_state_nxt;

    uop_bundle_t w_in, w_head, w_out;
    logic w_full, w_empty, w_push, w_pop, w_bypass;
    logic w_push_q, w_pop_q, w_wr, w_inc, w_dec, w_uop_ready;

    always_comb begin
        w_in = '{uop: in_uop, eoi: in_eoi, imm: in_imm, use_imm: in_use_imm,
                 pc: in_pc, except: in_except, src1_arch: in_src1_arch,
                 src2_arch: in_src2_arch, dest_arch: in_dest_arch};
    end

    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[PTR_W-1:0] == r_tail[PTR_W-1:0]) &&
                     (r_head[PTR_W] != r_tail[PTR_W]);

    uop_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr),
        .i_waddr (r_tail[PTR_W-1:0]),
        .i_wdata (w_in),
        .i_raddr (r_head[PTR_W-1:0]),
        .o_rdata (w_head)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_bypass    = 1'b0;
        w_uop_ready = 1'b0;
        w_out       = w_head;
        if (r_state == RUN) begin
            w_uop_ready = !w_empty;
`ifdef UOP_QUEUE_BYPASS_EN
            // Gated by rst so reset-time outputs stay at the zeroed head.
            if (w_empty && !flush && rst) begin
                w_bypass    = 1'b1;
                w_uop_ready = in_valid;
                w_out       = w_in;
            end
`endif
        end
        w_pop = w_uop_ready & uop_accept;
        if (flush) begin
            w_state_nxt = RUN;
        end else if (w_pop && w_out.except) begin
            w_state_nxt = HALT;
        end
    end

    // A bypassed-and-accepted uop is neither stored nor popped from storage.
    assign w_push   = in_valid & ~w_full;
    assign w_push_q = w_push & ~(w_bypass & uop_accept);
    assign w_pop_q  = w_pop & ~w_bypass;
    assign w_wr     = w_push_q & ~flush;
    assign w_inc    = w_push_q & in_eoi;
    assign w_dec    = w_pop_q & w_head.eoi;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_inst_count <= '0;
        end else begin
            if (w_push_q) r_tail <= r_tail + PTR_ONE;
            if (w_pop_q)  r_head <= r_head + PTR_ONE;
            unique case ({w_push_q, w_pop_q})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            unique case ({w_inc, w_dec})
                2'b10:   r_inst_count <= r_inst_count + CNT_ONE;
                2'b01:   r_inst_count <= r_inst_count - CNT_ONE;
                default: r_inst_count <= r_inst_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= RUN;
        else      r_state <= w_state_nxt;
    end

    assign in_ready   = ~w_full;
    assign uop_ready  = w_uop_ready;
    assign count      = r_count;
    assign inst_count = r_inst_count;
    assign halted     = (r_state == HALT);
    assign uop        = w_out.uop;
    assign eoi        = w_out.eoi;
    assign imm        = w_out.imm;
    assign use_imm    = w_out.use_imm;
    assign pc         = w_out.pc;
    assign except     = w_out.except;
    assign src1_arch  = w_out.src1_arch;
    assign src2_arch  = w_out.src2_arch;
    assign dest_arch  = w_out.dest_arch;

endmodule
